// File: rtl/sweep_pkg.sv
// Shared types and helpers for the partition sweep checker.
package sweep_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Widest supported partition output; popcount takes a fixed-width argument.
    localparam int unsigned MAX_PO_W = 16;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Number of set bits in a zero-extended output difference vector.
    function automatic logic [4:0] popcount(input logic [MAX_PO_W-1:0] v);
        logic [4:0] pc;
        pc = '0;
        for (int unsigned i = 0; i < MAX_PO_W; i++) begin
            pc = pc + 5'(v[i]);
        end
        return pc;
    endfunction

endpackage

// File: rtl/sweep_err_stats.sv
// Per-sample approx/exact comparison and error-statistics accumulators.
module sweep_err_stats
    import sweep_pkg::*;
#(
    parameter int unsigned PO_W  = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned BIT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [PO_W-1:0]  i_approx,
    input  logic [PO_W-1:0]  i_exact,
    output logic             o_mis,
    output logic [CNT_W-1:0] o_err_count,
    output logic [BIT_W-1:0] o_bit_err_count,
    output logic [PO_W-1:0]  o_max_abs_err
);

    logic [PO_W:0]      w_diff;
    logic [PO_W:0]      w_neg;
    logic [PO_W:0]      w_abs_full;
    logic [PO_W-1:0]    w_abs;
    logic [4:0]         w_pop;
    logic               w_mis;

    logic [CNT_W-1:0]   r_err_count;
    logic [BIT_W-1:0]   r_bit_err_count;
    logic [PO_W-1:0]    r_max_abs_err;

    // Compare captured sample: mismatch flag, flipped-bit count, unsigned |a-e|.
    always_comb begin
        w_mis      = (i_approx != i_exact);
        w_pop      = popcount(MAX_PO_W'(i_approx ^ i_exact));
        w_diff     = {1'b0, i_approx} - {1'b0, i_exact};
        w_neg      = '0 - w_diff;
        w_abs_full = w_diff[PO_W] ? w_neg : w_diff;
        w_abs      = w_abs_full[PO_W-1:0];
    end

    // Accumulate statistics on each accepted sample; clear when a sweep starts.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_err_count     <= '0;
            r_bit_err_count <= '0;
            r_max_abs_err   <= '0;
        end else if (i_en) begin
            r_err_count     <= r_err_count + CNT_W'(w_mis);
            r_bit_err_count <= r_bit_err_count + BIT_W'(w_pop);
            if (w_abs > r_max_abs_err) begin
                r_max_abs_err <= w_abs;
            end
        end
    end

    assign o_mis           = w_mis;
    assign o_err_count     = r_err_count;
    assign o_bit_err_count = r_bit_err_count;
    assign o_max_abs_err   = r_max_abs_err;

endmodule

// File: rtl/partition_sweep_checker.sv
// Exhaustive input sweep of an approximate partition against its exact
// reference, streaming each sample out and accumulating error statistics.
module partition_sweep_checker
    import sweep_pkg::*;
#(
    parameter  int unsigned PI_W   = 7,
    parameter  int unsigned PO_W   = 4,
    parameter  int unsigned SETTLE = 1,
    localparam int unsigned CNT_W  = PI_W + 1,
    localparam int unsigned BIT_W  = PI_W + clog2(PO_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [PI_W-1:0]  pi_o,
    input  logic [PO_W-1:0]  approx_po_i,
    input  logic [PO_W-1:0]  exact_po_i,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [PI_W-1:0]  sample_vec,
    output logic [PO_W-1:0]  sample_po,
    output logic             sample_mis,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [BIT_W-1:0] bit_err_count,
    output logic [PO_W-1:0]  max_abs_err
);

    state_t          r_state;
    state_t          w_next;

    logic [PI_W-1:0] r_pi;
    logic [3:0]      r_settle_cnt;
    logic            r_sample_valid;
    logic [PI_W-1:0] r_sample_vec;
    logic [PO_W-1:0] r_sample_po;
    logic [PO_W-1:0] r_sample_ex;

    logic            w_start_ok;
    logic            w_settled;
    logic            w_hs;
    logic            w_last;
    logic            w_busy;
    logic            w_done;

    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_settled  = (r_state == ST_SETTLE) && (r_settle_cnt == 4'(SETTLE - 1));
    assign w_hs       = (r_state == ST_SAMPLE) && r_sample_valid && sample_ready;
    // Terminal vector is detected explicitly so the counter never wraps.
    assign w_last     = (r_pi == '1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_settled) begin
                    w_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (w_hs) begin
                    w_next = w_last ? ST_DONE : ST_SETTLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        w_busy = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
        w_done = (r_state == ST_DONE);
    end

    // Vector counter, settle timer and sample capture/hold.
    // Capture happens on the edge that leaves SETTLE, so the sample is
    // valid during the single SAMPLE cycle and a vector costs SETTLE+1 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pi           <= '0;
            r_settle_cnt   <= '0;
            r_sample_valid <= 1'b0;
            r_sample_vec   <= '0;
            r_sample_po    <= '0;
            r_sample_ex    <= '0;
        end else begin
            if (w_start_ok) begin
                r_pi         <= '0;
                r_settle_cnt <= '0;
            end
            if (w_settled) begin
                r_sample_vec   <= r_pi;
                r_sample_po    <= approx_po_i;
                r_sample_ex    <= exact_po_i;
                r_sample_valid <= 1'b1;
            end else if (r_state == ST_SETTLE) begin
                r_settle_cnt <= r_settle_cnt + 4'd1;
            end
            if (w_hs) begin
                r_sample_valid <= 1'b0;
                if (!w_last) begin
                    r_pi         <= r_pi + PI_W'(1);
                    r_settle_cnt <= '0;
                end
            end
        end
    end

    sweep_err_stats #(
        .PO_W  (PO_W),
        .CNT_W (CNT_W),
        .BIT_W (BIT_W)
    ) u_stats (
        .clk             (clk),
        .rst             (rst),
        .i_clr           (w_start_ok),
        .i_en            (w_hs),
        .i_approx        (r_sample_po),
        .i_exact         (r_sample_ex),
        .o_mis           (sample_mis),
        .o_err_count     (err_count),
        .o_bit_err_count (bit_err_count),
        .o_max_abs_err   (max_abs_err)
    );

    assign pi_o         = r_pi;
    assign sample_valid = r_sample_valid;
    assign sample_vec   = r_sample_vec;
    assign sample_po    = r_sample_po;
    assign busy         = w_busy;
    assign done         = w_done;

endmodule

// File: doc/partition_sweep_checker.md
Name: partition_sweep_checker

Overview:
- Synthesizable, parametrised exhaustive-sweep engine for approximate-circuit partitions.
- Drives every input vector 0..2^PI_W-1 into a DUT partition and waits a settle time before sampling.
- Compares the approximate outputs against exact-reference outputs and streams each sample out through a valid/ready handshake.
- Accumulates error statistics (mismatch count, bit-flip count, max absolute error) for on-chip or emulation-based QoR evaluation of partitions.

Parameters:
- PI_W, 7, partition input width; sweep length is 2^PI_W vectors (legal 1..16).
- PO_W, 4, partition output width (legal 1..16).
- SETTLE, 1, cycles pi_o is held stable before sampling (legal 1..15).
- Derived localparam CNT_W = PI_W+1; BIT_W = PI_W+$clog2(PO_W+1).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a sweep; ignored unless in IDLE or DONE.
- pi_o  out  PI_W  current input vector to both the DUT and the reference.
- approx_po_i  in  PO_W  approximate partition outputs.
- exact_po_i  in  PO_W  exact reference outputs.
- sample_valid  out  1  captured sample available.
- sample_ready  in  1  consumer accepts sample.
- sample_vec  out  PI_W  vector associated with the sample.
- sample_po  out  PO_W  captured approx_po_i.
- sample_mis  out  1  approx != exact for this sample.
- busy  out  1  sweep in progress.
- done  out  1  sticky; sweep finished; statistics final.
- err_count  out  CNT_W  number of vectors with any mismatch.
- bit_err_count  out  BIT_W  sum of popcount(approx^exact) over all vectors.
- max_abs_err  out  PO_W  max |approx-exact|, unsigned interpretation.

Behaviour:
- Reset: state=IDLE; pi_o=0, sample_*=0, busy=0, done=0, all statistics=0. Reset mid-sweep aborts immediately; no partial statistics survive.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE + start: clear statistics and done, pi_o=0, settle counter=0, busy=1, go to SETTLE. Statistics clear on the same edge start is seen.
- SETTLE: pi_o stable. Count SETTLE cycles, then go to SAMPLE.
- SAMPLE, first cycle: capture approx/exact into sample regs; sample_valid=1.
- SAMPLE, holding: sample_valid and sample_* stay stable until sample_ready=1. Inputs are not re-sampled during a stall.
- Handshake (valid&&ready), all on the same edge:
  - err_count += mismatch.
  - bit_err_count += popcount.
  - max_abs_err = max(current, |a-e|).
  - sample_valid drops.
- After the handshake:
  - If pi_o == 2^PI_W-1: go to DONE, busy=0, done=1.
  - Otherwise: pi_o += 1, go to SETTLE.
- Throughput with sample_ready tied high: SETTLE+1 cycles per vector. Total sweep = 2^PI_W*(SETTLE+1) cycles from start to done (256 at defaults).
- Wrap-around: the internal vector counter never wraps. The terminal vector is detected explicitly, and pi_o holds 2^PI_W-1 in DONE.
- start while busy is ignored, with no effect on counters.
- Statistics are saturation-free by construction of the widths.
- |a-e| is computed in PO_W+1 bits, then truncated to PO_W.
- sample_ready asserted while sample_valid=0 has no effect.

Decomposition:
- Shared package sweep_pkg holds:
  - state enum {IDLE, SETTLE, SAMPLE, DONE};
  - function clog2;
  - function popcount(PO_W-generic, via a fixed 16-bit argument).
- One sub-module, sweep_err_stats: the combinational compare (mismatch, popcount, abs diff) plus the registered accumulators, with enable = handshake and clear = start. The FSM and vector counter stay in the top.

Test Plan:
- Defaults, approx=exact=pi[3:0] (both wired to the same function), ready=1, start pulse:
  - done at cycle 256 after start;
  - err_count=0, bit_err_count=0, max_abs_err=0;
  - 128 samples with sample_vec 0..127 in order.
- Defaults, exact=pi[3:0], approx=pi[3:0]&4'b1110:
  - err_count=64, bit_err_count=64, max_abs_err=1.
- Defaults, exact=pi[3:0], approx=4'b0000:
  - err_count=120, bit_err_count=256, max_abs_err=15.
- Backpressure: ready low for 5 cycles at vector 10:
  - sample_vec=10 and sample_po held stable, pi_o unchanged;
  - total sweep = 261 cycles; statistics identical to the no-stall run.
- Reset asserted at vector 40:
  - next cycle IDLE, all outputs 0.
- start during busy: ignored.
- A new start after done clears done and the statistics, then re-sweeps with an identical result.
- PI_W=3, PO_W=2, SETTLE=3, approx=~exact:
  - done after 32 cycles;
  - err_count=8, bit_err_count=16;
  - max_abs_err=3 when exact=0.
